// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared access-size codes and geometry defaults for the data memory
// Purpose: op encodings for dmOP (word/half/byte) and default array geometry.
// Ports: none (package).
package dm_pkg;

  // Access size driven by the control unit alongside dextOP.
  // Encoding 2'd3 is undefined and is treated as a word access.
  typedef enum logic [1:0] {
    DM_W = 2'd0,
    DM_H = 2'd1,
    DM_B = 2'd2
  } dm_op_e;

  localparam int unsigned DM_WORDS_DEFAULT = 3072;
  localparam int unsigned DM_IDX_W_DEFAULT = 12;

endpackage

// File: rtl/dm_if.sv
// rtl/dm_if.sv - M-stage data memory access bus
// Purpose: groups the request (WE/RE/A/WD/dmOP) and response (RD/BE/addrExc) signals.
// Ports:
//   WE, RE     store / load request
//   A          byte address
//   WD         right-aligned store data
//   dmOP       access size (dm_pkg::dm_op_e encoding)
//   RD         aligned word read back
//   BE         byte enables of the current access
//   addrExc    misaligned or out-of-range access
interface dm_if;
  logic        WE;
  logic        RE;
  logic [31:0] A;
  logic [31:0] WD;
  logic [1:0]  dmOP;
  logic [31:0] RD;
  logic [3:0]  BE;
  logic        addrExc;

  modport master (
    output WE, RE, A, WD, dmOP,
    input  RD, BE, addrExc
  );

  modport slave (
    input  WE, RE, A, WD, dmOP,
    output RD, BE, addrExc
  );
endinterface

// File: rtl/dm_be.sv
// rtl/dm_be.sv - byte-enable, lane-replication and alignment decode for dm
// Purpose: purely combinational map of access size and low address bits to
//          byte enables, store data replicated onto every byte lane, and a
//          misalignment flag. Range checking is left to the caller.
// Ports:
//   i_op        access size
//   i_a_lo      A[1:0]
//   i_wd        right-aligned store data
//   o_be        byte enables (0 when misaligned)
//   o_lane      store data placed so that every enabled lane sees its byte
//   o_misalign  access not naturally aligned for its size
module dm_be
  import dm_pkg::*;
(
  input  logic [1:0]  i_op,
  input  logic [1:0]  i_a_lo,
  input  logic [31:0] i_wd,
  output logic [3:0]  o_be,
  output logic [31:0] o_lane,
  output logic        o_misalign
);

  always_comb begin
    o_be       = 4'b0000;
    o_lane     = i_wd;
    o_misalign = 1'b0;
    case (dm_op_e'(i_op))
      DM_H: begin
        o_lane     = {2{i_wd[15:0]}};
        o_misalign = i_a_lo[0];
        o_be       = i_a_lo[1] ? 4'b1100 : 4'b0011;
      end
      DM_B: begin
        o_lane = {4{i_wd[7:0]}};
        o_be   = 4'b0001 << i_a_lo;
      end
      default: begin
        // DM_W and the undefined encoding both act as a full-word access.
        o_lane     = i_wd;
        o_misalign = |i_a_lo;
        o_be       = 4'b1111;
      end
    endcase
    if (o_misalign) begin
      o_be = 4'b0000;
    end
  end

endmodule

// File: rtl/dm.sv
// rtl/dm.sv - word-organised M-stage data memory with byte-lane stores
// Purpose: holds the word array, commits byte-enabled stores on the rising
//          edge, returns the aligned word combinationally and flags
//          misaligned / out-of-range accesses (which are suppressed).
// Ports:
//   clk     write clock
//   reset   asynchronous active-high; clears every word immediately
//   bus     dm_if.slave (WE, RE, A, WD, dmOP -> RD, BE, addrExc)
module dm
  import dm_pkg::*;
#(
  parameter int unsigned WORDS = DM_WORDS_DEFAULT,
  parameter int unsigned IDX_W = DM_IDX_W_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  dm_if.slave  bus
);

  // 33-bit compare so that 4*WORDS never overflows and high addresses
  // cannot alias low words through index truncation.
  localparam logic [32:0] LIMIT = 33'(4 * WORDS);

  logic [31:0]      r_mem [WORDS];

  logic [IDX_W-1:0] w_idx;
  logic             w_in_range;
  logic [3:0]       w_be_raw;
  logic [31:0]      w_lane;
  logic             w_misalign;
  logic             w_wr_en;

  assign w_idx      = bus.A[IDX_W+1:2];
  assign w_in_range = ({1'b0, bus.A} < LIMIT);

  dm_be u_be (
    .i_op       (bus.dmOP),
    .i_a_lo     (bus.A[1:0]),
    .i_wd       (bus.WD),
    .o_be       (w_be_raw),
    .o_lane     (w_lane),
    .o_misalign (w_misalign)
  );

  assign bus.BE      = w_in_range ? w_be_raw : 4'b0000;
  assign bus.addrExc = (bus.WE || bus.RE) && (!w_in_range || w_misalign);
  assign w_wr_en     = bus.WE && !bus.addrExc;

  // Reset gating is redundant with the cleared array but keeps RD at zero
  // even in the same delta as reset assertion.
  assign bus.RD = (w_in_range && !reset) ? r_mem[w_idx] : 32'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(WORDS); i++) begin
        r_mem[i] <= 32'h0;
      end
    end else if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.BE[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_lane[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dm.sv
// tb/tb_dm.sv - self-checking bench for dm against a behavioural byte-array model
module tb_dm;

  localparam int WORDS = 3072;
  localparam logic [31:0] TOP = 32'(4 * WORDS);

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  bit   run_cmp;

  logic [31:0] m_mem [WORDS];

  dm_if bus ();

  dm #(.WORDS(WORDS), .IDX_W(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int size_of(logic [1:0] op);
    if (op == 2'd1) return 2;
    if (op == 2'd2) return 1;
    return 4;
  endfunction

  function automatic bit legal(logic [31:0] a, logic [1:0] op);
    return (a < TOP) && ((a % size_of(op)) == 0);
  endfunction

  function automatic logic [3:0] exp_be(logic [31:0] a, logic [1:0] op);
    int sz;
    sz = size_of(op);
    if (!legal(a, op)) return 4'b0000;
    return 4'(((1 << sz) - 1) << (a % 4));
  endfunction

  function automatic logic exp_exc(logic we, logic re, logic [31:0] a, logic [1:0] op);
    return (we || re) && !legal(a, op);
  endfunction

  function automatic logic [31:0] exp_rd(logic [31:0] a);
    if (reset || a >= TOP) return 32'h0;
    return m_mem[a / 4];
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t A=%h op=%0d)", name, act, exp, $time, bus.A, bus.dmOP);
    end
  endtask

  // Model: a store writes size bytes starting at byte offset A%4, taking
  // consecutive bytes of WD from the bottom.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WORDS; i++) m_mem[i] <= 32'h0;
    end else if (bus.WE && legal(bus.A, bus.dmOP)) begin
      for (int k = 0; k < size_of(bus.dmOP); k++) begin
        m_mem[bus.A / 4][8*((bus.A % 4) + k) +: 8] <= bus.WD[8*k +: 8];
      end
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("rd", bus.RD, exp_rd(bus.A));
      chk("be", {28'h0, bus.BE}, {28'h0, exp_be(bus.A, bus.dmOP)});
      chk("exc", {31'h0, bus.addrExc}, {31'h0, exp_exc(bus.WE, bus.RE, bus.A, bus.dmOP)});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic set(logic we, logic re, logic [31:0] a, logic [31:0] wd, logic [1:0] op);
    bus.WE   = we;
    bus.RE   = re;
    bus.A    = a;
    bus.WD   = wd;
    bus.dmOP = op;
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    run_cmp = 1'b0;
    reset   = 1'b0;
    set(0, 0, 32'h0, 32'h0, 2'd0);
    #2;
    reset   = 1'b1;
    run_cmp = 1'b1;
    #1 chk("rd_in_reset", bus.RD, 32'h0);
    repeat (2) step();
    reset = 1'b0;

    // sw then read back
    set(1, 0, 32'h10, 32'h12345678, 2'd0);
    step();
    set(0, 1, 32'h10, 32'h0, 2'd0);
    at_neg();
    chk("sw_rd", bus.RD, 32'h12345678);
    chk("sw_be", {28'h0, bus.BE}, 32'hF);
    chk("sw_exc", {31'h0, bus.addrExc}, 32'h0);

    // sb into lane 3, then sh into lanes 1:0
    set(1, 0, 32'h13, 32'h000000AB, 2'd2);
    at_neg();
    chk("sb_be", {28'h0, bus.BE}, 32'h8);
    step();
    set(0, 1, 32'h10, 32'h0, 2'd0);
    at_neg();
    chk("sb_rd", bus.RD, 32'hAB345678);
    set(1, 0, 32'h10, 32'h0000BEEF, 2'd1);
    step();
    set(0, 1, 32'h10, 32'h0, 2'd0);
    at_neg();
    chk("sh_rd", bus.RD, 32'hAB34BEEF);

    // misaligned stores
    set(1, 0, 32'h11, 32'h0000FFFF, 2'd1);
    at_neg();
    chk("sh_mis_exc", {31'h0, bus.addrExc}, 32'h1);
    chk("sh_mis_be", {28'h0, bus.BE}, 32'h0);
    step();
    set(1, 0, 32'h12, 32'hFFFFFFFF, 2'd0);
    at_neg();
    chk("sw_mis_exc", {31'h0, bus.addrExc}, 32'h1);
    chk("sw_mis_be", {28'h0, bus.BE}, 32'h0);
    step();
    set(0, 1, 32'h10, 32'h0, 2'd0);
    at_neg();
    chk("mis_unchanged", bus.RD, 32'hAB34BEEF);

    // top boundary
    set(1, 0, TOP - 32'd4, 32'hCAFEF00D, 2'd0);
    at_neg();
    chk("top_exc", {31'h0, bus.addrExc}, 32'h0);
    step();
    set(1, 0, TOP, 32'h55555555, 2'd0);
    at_neg();
    chk("oor_exc", {31'h0, bus.addrExc}, 32'h1);
    chk("oor_rd", bus.RD, 32'h0);
    chk("oor_be", {28'h0, bus.BE}, 32'h0);
    step();
    set(0, 1, 32'h0, 32'h0, 2'd0);
    at_neg();
    chk("no_wrap", bus.RD, 32'h0);
    bus.A = TOP - 32'd4;
    #1 chk("top_rd", bus.RD, 32'hCAFEF00D);

    // same-cycle read/write
    step();
    set(1, 0, 32'h20, 32'hFFFFFFFF, 2'd0);
    #1 chk("rdw_before", bus.RD, 32'h0);
    step();
    bus.WE = 1'b0;
    #1 chk("rdw_after", bus.RD, 32'hFFFFFFFF);

    // reset asserted mid-store
    step();
    set(1, 0, 32'h10, 32'h11112222, 2'd0);
    #1 chk("pre_reset", bus.RD, 32'hAB34BEEF);
    reset = 1'b1;
    #1 chk("reset_clr_10", bus.RD, 32'h0);
    bus.A = 32'h20;
    #1 chk("reset_clr_20", bus.RD, 32'h0);
    bus.A = 32'h10;
    step();
    chk("reset_no_commit", bus.RD, 32'h0);
    bus.WE = 1'b0;
    reset  = 1'b0;
    #1 chk("after_reset", bus.RD, 32'h0);

    // randomized traffic
    for (int it = 0; it < 800; it++) begin
      logic [31:0] a;
      step();
      case ($urandom_range(0, 3))
        0, 1:    a = $urandom_range(0, 255);
        2:       a = TOP - 32'd32 + 32'($urandom_range(0, 40));
        default: a = $urandom;
      endcase
      set(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom, 2'($urandom_range(0, 3)));
      if (it == 400) begin
        #2 reset = 1'b1;
        #1 reset = 1'b0;
      end
    end
    step();
    set(0, 0, 32'h0, 32'h0, 2'd0);
    at_neg();
    run_cmp = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
